// File: rtl/vec_imm_expander.sv
// Scalar immediate -> LANES x N vector operand (ZEXT/SEXT/RAMP/MASK) with valid/ready on both sides.
// Define VEC_IMM_RAMP_SAT_EN to make RAMP lanes saturate at 2^N-1 instead of wrapping.

module vec_imm_lane #(
  parameter int N = 16
) (
  input  logic [1:0]   mode,
  input  logic [7:0]   base,
  input  logic         bit_sel,
  output logic [N-1:0] val
);
  // RAMP lanes come from the build pipeline, so the broadcast value is just a clear.
  always_comb begin
    case (mode)
      2'b00:   val = N'(base);
      2'b01:   val = N'($signed(base));
      2'b11:   val = {N{bit_sel}};
      default: val = '0;
    endcase
  end
endmodule

module vec_imm_expander #(
  parameter int LANES = 16,
  parameter int N     = 16,
  parameter int IMM_W = 10,
  parameter int LPC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [IMM_W-1:0]   immediate,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] extended,
  output logic               busy
);
  localparam int LW = $clog2(LANES);
`ifdef VEC_IMM_RAMP_SAT_EN
  // Headroom so acc + LPC*stride never wraps before the clamp.
  localparam int AW = N + $clog2(LPC*4+1) + 1;
  localparam logic [AW-1:0] MAXW = {{(AW-N){1'b0}}, {N{1'b1}}};
`else
  localparam int AW = N;
`endif

  typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;

  state_t                    state;
  logic [LANES-1:0][N-1:0]   ext_q;
  logic [LANES-1:0][N-1:0]   fill;
  logic [LPC-1:0][N-1:0]     rl;
  logic [AW-1:0]             acc, nacc, t;
  logic [2:0]                strd;
  logic [LW-1:0]             k;
  logic                      accept;

  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign extended = ext_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_imm_lane #(.N(N)) u_lane (
      .mode    (mode),
      .base    (immediate[7:0]),
      .bit_sel (immediate[i%8]),
      .val     (fill[i])
    );
  end

  always_comb begin
    t  = '0;
    rl = '0;
    for (int j = 0; j < LPC; j++) begin
      t = acc + AW'(j) * AW'(strd);
`ifdef VEC_IMM_RAMP_SAT_EN
      rl[j] = (t > MAXW) ? {N{1'b1}} : t[N-1:0];
`else
      rl[j] = t[N-1:0];
`endif
    end
    nacc = acc + AW'(LPC) * AW'(strd);
`ifdef VEC_IMM_RAMP_SAT_EN
    if (nacc > MAXW) nacc = MAXW;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ext_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      strd      <= '0;
      k         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            ext_q <= fill;
            strd  <= {1'b0, immediate[9:8]} + 3'd1;
            acc   <= AW'(immediate[7:0]);
            k     <= '0;
            busy  <= 1'b1;
            if (mode == 2'b10) begin
              state     <= BUILD;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        BUILD: begin
          for (int j = 0; j < LPC; j++) ext_q[k + LW'(j)] <= rl[j];
          acc <= nacc;
          k   <= k + LW'(LPC);
          if (k == LW'(LANES - LPC)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vec_imm_expander.sv
// Randomised self-checking bench for vec_imm_expander against a lane-formula reference model.
module tb_vec_imm_expander;
  localparam int L = 16, N = 16, LPC = 4;
  localparam int N8 = 8, LPC8 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]     mode;
  logic [9:0]     imm;
  logic [L*N-1:0] ext;

  logic            in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [1:0]      mode8;
  logic [9:0]      imm8;
  logic [L*N8-1:0] ext8;

  int tests = 0, fails = 0;

  vec_imm_expander #(.LANES(L), .N(N), .IMM_W(10), .LPC(LPC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .immediate(imm), .out_valid(out_valid), .out_ready(out_ready), .extended(ext), .busy(busy));

  vec_imm_expander #(.LANES(L), .N(N8), .IMM_W(10), .LPC(LPC8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .mode(mode8),
    .immediate(imm8), .out_valid(out_valid8), .out_ready(out_ready8), .extended(ext8), .busy(busy8));

  // Reference: each lane straight from the fill-mode formula.
  function automatic longint unsigned lane_val(input logic [1:0] m, input logic [9:0] im,
                                              input int i, input int n);
    longint unsigned mx, b, s, v;
    mx = (64'd1 << n) - 1;
    b  = longint'(im[7:0]);
    s  = longint'(im[9:8]) + 1;
    case (m)
      2'd0: v = b;
      2'd1: v = im[7] ? ((mx & ~64'hFF) | b) : b;
      2'd2: begin
        v = b + longint'(i) * s;
`ifdef VEC_IMM_RAMP_SAT_EN
        if (v > mx) v = mx;
`else
        v = v & mx;
`endif
      end
      default: v = im[i%8] ? mx : 64'd0;
    endcase
    return v;
  endfunction

  function automatic logic [255:0] exp_vec(input logic [1:0] m, input logic [9:0] im, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < L; i++) r = r | (256'(lane_val(m, im, i, n)) << (i*n));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] m, input logic [9:0] im);
    mode = m; imm = im; in_valid = 1'b1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL issue_in_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    mode = 2'($urandom); imm = 10'($urandom);  // must be ignored after accept
  endtask

  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = 1; busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 50) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick(); lat++;
    end
  endtask

  task automatic consume();
    logic [L*N-1:0] held;
    held = ext;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ext !== held) begin
      fails++; $display("FAIL consume ov=%b busy=%b ext=%h want ov=0 busy=0 ext=%h", out_valid, busy, ext, held);
    end
  endtask

  task automatic check_result(input string nm, input logic [1:0] m, input logic [9:0] im, input int want_lat);
    int lat; bit bok; logic [255:0] e;
    wait_valid(lat, bok);
    e = exp_vec(m, im, N);
    tests++;
    if (lat != want_lat || !bok) begin
      fails++; $display("FAIL %s_latency got %0d busy_ok=%0d want %0d busy_ok=1", nm, lat, bok, want_lat);
    end
    tests++;
    if (ext !== e) begin
      fails++; $display("FAIL %s_data got %h want %h", nm, ext, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; out_ready = 0; mode = 0; imm = 0;
    in_valid8 = 0; out_ready8 = 0; mode8 = 0; imm8 = 0;
    tick(); tick();
    tests++;
    if (out_valid !== 0 || busy !== 0 || ext !== '0 || in_ready !== 0) begin
      fails++; $display("FAIL reset ov=%b busy=%b ext=%h rdy=%b want 0,0,0,0", out_valid, busy, ext, in_ready);
    end
    rst = 1'b0; #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid8 !== 0 || busy8 !== 0 || ext8 !== '0) begin
      fails++; $display("FAIL reset_release rdy=%b ov8=%b busy8=%b ext8=%h", in_ready, out_valid8, busy8, ext8);
    end
  endtask

  task automatic test_zext();
    issue(2'b00, 10'h3A5);
    check_result("zext", 2'b00, 10'h3A5, 1);
    tests++;
    if (ext[7*N +: N] !== 16'h00A5) begin
      fails++; $display("FAIL zext_lane7 got %h want 00a5", ext[7*N +: N]);
    end
    consume();
  endtask

  task automatic test_sext();
    issue(2'b01, 10'h080);
    check_result("sext_neg", 2'b01, 10'h080, 1);
    tests++;
    if (ext[0 +: N] !== 16'hFF80) begin
      fails++; $display("FAIL sext_lane0 got %h want ff80", ext[0 +: N]);
    end
    consume();
    issue(2'b01, 10'h07F);
    check_result("sext_pos", 2'b01, 10'h07F, 1);
    consume();
  endtask

  task automatic test_ramp();
    issue(2'b10, 10'h10A);
    check_result("ramp", 2'b10, 10'h10A, L/LPC + 1);
    tests++;
    if (ext[15*N +: N] !== 16'h0028) begin
      fails++; $display("FAIL ramp_lane15 got %h want 0028", ext[15*N +: N]);
    end
    consume();
  endtask

  task automatic test_wrap8();
    int lat; logic [255:0] e; logic [7:0] w15, w8;
`ifdef VEC_IMM_RAMP_SAT_EN
    w15 = 8'hFF; w8 = 8'hFF;
`else
    w15 = 8'h0E; w8 = 8'h00;
`endif
    mode8 = 2'b10; imm8 = 10'h1F0; in_valid8 = 1'b1;
    tick(); in_valid8 = 1'b0; imm8 = 10'h3FF;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 50) begin tick(); lat++; end
    e = exp_vec(2'b10, 10'h1F0, N8);
    tests++;
    if (lat != L/LPC8 + 1 || ext8 !== e[L*N8-1:0]) begin
      fails++; $display("FAIL wrap8 lat=%0d ext=%h want lat=%0d ext=%h", lat, ext8, L/LPC8 + 1, e[L*N8-1:0]);
    end
    tests++;
    if (ext8[15*8 +: 8] !== w15 || ext8[8*8 +: 8] !== w8) begin
      fails++; $display("FAIL wrap8_lanes l15=%h l8=%h want %h %h", ext8[15*8 +: 8], ext8[8*8 +: 8], w15, w8);
    end
    out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;
  endtask

  task automatic test_mask_backpressure();
    logic [255:0] e;
    issue(2'b11, 10'h0C5);
    check_result("mask", 2'b11, 10'h0C5, 1);
    e = exp_vec(2'b11, 10'h0C5, N);
    for (int c = 0; c < 6; c++) begin
      tick();
      tests++;
      if (out_valid !== 1 || in_ready !== 0 || ext !== e) begin
        fails++; $display("FAIL mask_hold c=%0d ov=%b rdy=%b ext=%h want 1 0 %h", c, out_valid, in_ready, ext, e);
      end
    end
    // back-to-back: consume and accept on the same edge
    out_ready = 1'b1; in_valid = 1'b1; mode = 2'b00; imm = 10'h011; #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_in_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    e = exp_vec(2'b00, 10'h011, N);
    tests++;
    if (out_valid !== 1 || ext !== e) begin
      fails++; $display("FAIL b2b_result ov=%b ext=%h want 1 %h", out_valid, ext, e);
    end
    consume();
  endtask

  task automatic test_random();
    logic [1:0] m; logic [9:0] im; logic [255:0] e;
    for (int r = 0; r < 20; r++) begin
      m = 2'($urandom); im = 10'($urandom);
      issue(m, im);
      check_result("rand", m, im, (m == 2'b10) ? L/LPC + 1 : 1);
      e = exp_vec(m, im, N);
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        tick();
        tests++;
        if (out_valid !== 1 || ext !== e) begin
          fails++; $display("FAIL rand_hold ov=%b ext=%h want 1 %h", out_valid, ext, e);
        end
      end
      consume();
    end
  endtask

  task automatic test_reset_mid_build();
    bit seen;
    issue(2'b10, 10'h2C3);
    tick();
    rst = 1'b1; #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL rst_in_ready got %b want 0", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 0 || busy !== 0 || ext !== '0) begin
      fails++; $display("FAIL rst_mid_build ov=%b busy=%b ext=%h want 0 0 0", out_valid, busy, ext);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++; $display("FAIL rst_no_result got activity after abort want none");
    end
  endtask

  initial begin
    test_reset();
    test_zext();
    test_sext();
    test_ramp();
    test_wrap8();
    test_mask_backpressure();
    test_random();
    test_reset_mid_build();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
